// File: rtl/serial_rx_pkg.sv
// Shared types for the serial parity receiver: framing states, parity
// states and the error counter width.
package serial_rx_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  typedef enum logic {EVEN, ODD} parity_t;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/parity_tracker.sv
// Running even/odd tracker for the data and parity bits of one frame.
// The clear input has priority over the bit update and restarts at EVEN.
module parity_tracker
  import serial_rx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic bit_en,
  input  logic bit_in,
  output logic odd
);

  parity_t state, state_next;

  // parity state register
  always_ff @(posedge clk) begin
    if (reset) state <= EVEN;
    else       state <= state_next;
  end

  // toggle on every qualified 1 bit; clear returns to EVEN
  always_comb begin
    state_next = state;
    if (clear)
      state_next = EVEN;
    else if (bit_en && bit_in)
      state_next = (state == EVEN) ? ODD : EVEN;
  end

  assign odd = (state == ODD);

endmodule

// File: rtl/serial_parity_receiver.sv
// Serial frame receiver: start / DATA_W data bits (LSB first) / even parity /
// stop. Delivers every frame with parity and framing error flags.
// Optional build macro SPR_ERR_COUNT_EN adds a saturating 16-bit error counter
// on the err_count port.
module serial_parity_receiver
  import serial_rx_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
`ifdef SPR_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_t         state, state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              start_seen;
  logic              track_en;
  logic              parity_odd;

  assign start_seen = bit_en && (state == IDLE) && !serial_in;
  assign track_en   = bit_en && ((state == DATA) || (state == PARITY));
  assign busy       = (state != IDLE);

  parity_tracker u_parity (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_seen),
    .bit_en (track_en),
    .bit_in (serial_in),
    .odd    (parity_odd)
  );

  // framing state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // framing transitions, only on bit strobes
  always_comb begin
    state_next = state;
    if (bit_en) begin
      case (state)
        IDLE:    if (!serial_in) state_next = DATA;
        DATA:    if (bit_cnt == LAST_BIT) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // bit counter, data shift register and frame result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: if (!serial_in) bit_cnt <= '0;
          DATA: begin
            shift_reg[bit_cnt] <= serial_in;
            if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;
          end
          STOP: begin
            data_out   <= shift_reg;
            parity_err <= parity_odd;
            frame_err  <= !serial_in;
            data_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPR_ERR_COUNT_EN
  // count delivered frames carrying any error, saturating at all ones
  always_ff @(posedge clk) begin
    if (reset)
      err_count <= '0;
    else if (data_valid && (parity_err || frame_err) && (err_count != '1))
      err_count <= err_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Self-checking bench for serial_parity_receiver (DATA_W = 8).
// Directed frame table, multi-cycle corner sequences and randomized frames
// checked against a frame-level reference model.
module tb_serial_parity_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b1;
  logic       bit_en = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
`ifdef SPR_ERR_COUNT_EN
  logic [15:0] err_count;
  int unsigned model_err = 0;
`endif

  int total = 0;
  int passed = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  obs_t obs_q[$];
  logic prev_dv = 1'b0;

  serial_parity_receiver #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef SPR_ERR_COUNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // record every pulse and check it never lasts two cycles
  always @(posedge clk) begin
    #1;
    if (data_valid === 1'b1) begin
      obs_q.push_back('{data_out, parity_err, frame_err});
      total++;
      if (prev_dv !== 1'b1) passed++;
      else $display("FAIL dv_consecutive actual=1 required=0");
    end
    prev_dv = data_valid;
  end

  // called at a negedge; one strobed bit followed by gap cycles of line noise
  task automatic send_bit(input logic b, input int gap);
    serial_in = b;
    bit_en = 1'b1;
    @(negedge clk);
    bit_en = 1'b0;
    for (int g = 0; g < gap; g++) begin
      serial_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(p, gap);
    send_bit(s, gap);
  endtask

  task automatic settle();
    serial_in = 1'b1;
    bit_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic model_frame(input logic pe, input logic fe);
`ifdef SPR_ERR_COUNT_EN
    if ((pe || fe) && model_err < 32'hFFFF) model_err++;
`else
    if (pe && fe) begin end
`endif
  endtask

  task automatic expect_one(input string name, input logic [7:0] d, input logic pe, input logic fe);
    chk({name, "_pulses"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      chk({name, "_data"}, obs_q[0].d, d);
      chk({name, "_perr"}, obs_q[0].pe, pe);
      chk({name, "_ferr"}, obs_q[0].fe, fe);
    end
    obs_q.delete();
    chk({name, "_busy"}, busy, 1'b0);
    model_frame(pe, fe);
`ifdef SPR_ERR_COUNT_EN
    @(negedge clk);
    chk({name, "_errcnt"}, err_count, model_err[15:0]);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bit_en = 1'b0;
    serial_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
`ifdef SPR_ERR_COUNT_EN
    model_err = 0;
`endif
    obs_q.delete();
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_data_valid", data_valid, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    do_reset();
`ifdef SPR_ERR_COUNT_EN
    chk("rst_err_count", err_count, 16'h0000);
`endif

    // directed frame table, one strobe per 4 clocks
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, 3);
      settle();
      expect_one($sformatf("vec%0d", v), vecs[v].exp_data, vecs[v].exp_perr, vecs[v].exp_ferr);
    end

    // idle strobes with line high must not start a frame
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_pulses", obs_q.size(), 0);

    // reset after the 4th data bit drops the partial frame
    send_bit(1'b0, 3);
    chk("mid_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data_out", data_out, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_pulses", obs_q.size(), 0);
    obs_q.delete();
`ifdef SPR_ERR_COUNT_EN
    model_err = 0;
`endif
    send_frame(8'hFF, 1'b0, 1'b1, 3);
    settle();
    expect_one("after_rst", 8'hFF, 1'b0, 1'b0);

    // back-to-back frames with bit_en held high every cycle
    send_frame(8'h00, 1'b0, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    settle();
    chk("b2b_pulses", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("b2b_data0", obs_q[0].d, 8'h00);
      chk("b2b_err0", {obs_q[0].pe, obs_q[0].fe}, 2'b00);
      chk("b2b_data1", obs_q[1].d, 8'hFF);
      chk("b2b_err1", {obs_q[1].pe, obs_q[1].fe}, 2'b00);
    end
    obs_q.delete();

    // randomized frames against the frame-level model
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic p, s;
      int gap;
      d = 8'($urandom_range(0, 255));
      p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      s = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 3);
      for (int k = $urandom_range(0, 2); k > 0; k--) send_bit(1'b1, gap);
      send_frame(d, p, s, gap);
      settle();
      expect_one($sformatf("rnd%0d", n), d, (^d) ^ p, ~s);
    end

`ifdef SPR_ERR_COUNT_EN
    // three bad frames and one good one from a fresh reset
    do_reset();
    send_frame(8'h01, 1'b0, 1'b1, 3); settle(); expect_one("cnt_bad0", 8'h01, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 3); settle(); expect_one("cnt_bad1", 8'h3C, 1'b0, 1'b1);
    send_frame(8'h80, 1'b0, 1'b0, 3); settle(); expect_one("cnt_bad2", 8'h80, 1'b1, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b1, 3); settle(); expect_one("cnt_good", 8'hA5, 1'b0, 1'b0);
    chk("cnt_three", err_count, 16'd3);
    // saturation
    force dut.err_count = 16'hFFFF;
    @(negedge clk);
    release dut.err_count;
    model_err = 32'hFFFF;
    send_frame(8'h01, 1'b0, 1'b1, 3); settle(); expect_one("cnt_sat", 8'h01, 1'b1, 1'b0);
    chk("cnt_sat_value", err_count, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
